// File: rtl/temp_monitor.sv
// temp_monitor: averages windows of 2^AVG_LOG2 readings and drives an alarm LED through a hysteresis FSM.
// Optional build macro TEMP_MON_STICKY_EN latches the alarm until acknowledged with clear.
module temp_monitor #(
  parameter int WIDTH     = 8,
  parameter int AVG_LOG2  = 2,
  parameter int HI_THRESH = 200,
  parameter int LO_THRESH = 180,
  parameter int HOLD      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sw,
  input  logic             clear,
  output logic [WIDTH-1:0] avg,
  output logic             avg_valid,
  output logic [1:0]       state,
  output logic             led
);

  // A zero-width counter is not legal, so AVG_LOG2=0 keeps a 1-bit counter pinned at zero
  localparam int CW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int ACCW = WIDTH + AVG_LOG2;
  localparam int HCW  = (HOLD > 1) ? $clog2(HOLD + 1) : 1;

  localparam logic [CW-1:0]    LAST_IDX = CW'((1 << AVG_LOG2) - 1);
  localparam logic [WIDTH-1:0] HI       = WIDTH'(HI_THRESH);
  localparam logic [WIDTH-1:0] LO       = WIDTH'(LO_THRESH);
  localparam logic [HCW-1:0]   HOLD_N   = HCW'(HOLD);

  typedef enum logic [1:0] {
    COOL = 2'd0,
    PEND = 2'd1,
    HOT  = 2'd2
  } state_t;

  logic [ACCW-1:0] acc_q;
  logic [CW-1:0]   cnt_q;
  logic [ACCW-1:0] sum;
  logic            last_sample;
  state_t          state_q, state_d;
  logic [HCW-1:0]  hold_q, hold_d;

  assign sum         = acc_q + ACCW'(sw);
  assign last_sample = (cnt_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (sample_valid) begin
        if (last_sample) begin
          acc_q     <= '0;
          cnt_q     <= '0;
          avg       <= WIDTH'(sum >> AVG_LOG2);
          avg_valid <= 1'b1;
        end else begin
          acc_q <= sum;
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COOL;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // The FSM only looks at avg in the single cycle it is freshly updated
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      COOL: begin
        if (avg_valid && avg >= HI) begin
          hold_d  = HCW'(1);
          state_d = (HOLD == 1) ? HOT : PEND;
        end
      end
      PEND: begin
        if (avg_valid) begin
          if (avg >= HI) begin
            hold_d = hold_q + HCW'(1);
            if (hold_d >= HOLD_N) state_d = HOT;
          end else begin
            hold_d  = '0;
            state_d = COOL;
          end
        end
      end
      HOT: begin
`ifdef TEMP_MON_STICKY_EN
        if (clear) begin
          hold_d  = '0;
          state_d = COOL;
        end
`else
        if (avg_valid && avg <= LO) begin
          hold_d  = '0;
          state_d = COOL;
        end
`endif
      end
      default: begin
        hold_d  = '0;
        state_d = COOL;
      end
    endcase
  end

`ifndef TEMP_MON_STICKY_EN
  logic unused_clear;
  assign unused_clear = clear;
`else
  logic unused_lo;
  assign unused_lo = ^LO;
`endif

  assign state = state_q;
  assign led   = (state_q == HOT);

endmodule
